// File: rtl/bitscan_pkg.sv
// Shared constants and state encoding for the set-bit position scanner.
package bitscan_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_prienc32.sv
// 32-to-5 priority encoder with found flag; MSB_FIRST picks the winning end.
module bit_prienc32
  import bitscan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Ascending walk: LSB-first keeps the first hit, MSB-first lets later hits override.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_vec[i] && (MSB_FIRST || !o_found)) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitpos_scanner.sv
// Expands a 32-bit word into a valid/ready stream of its set-bit indices.
// Build option: BITSCAN_MSB_FIRST_EN emits indices in descending order.
module bitpos_scanner
  import bitscan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] numin,
  input  logic             pos_ready,
  output logic             pos_valid,
  output logic [IDX_W-1:0] pos,
  output logic             last,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done
);

`ifdef BITSCAN_MSB_FIRST_EN
  localparam bit LP_MSB_FIRST = 1'b1;
`else
  localparam bit LP_MSB_FIRST = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_work;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_popcnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_single;
  logic             w_accept;
  logic             w_take;

  bit_prienc32 #(
    .MSB_FIRST(LP_MSB_FIRST)
  ) u_prienc (
    .i_vec  (r_work),
    .o_idx  (w_idx),
    .o_found(w_found)
  );

  always_comb begin
    w_popcnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + CNT_W'(numin[i]);
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign w_single = (r_work != '0) && ((r_work & (r_work - WIDTH'(1))) == '0);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_take       = 1'b0;
    pos_valid    = 1'b0;
    pos          = '0;
    last         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (numin != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        pos_valid = 1'b1;
        pos       = w_idx;
        last      = w_single && w_found;
        busy      = 1'b1;
        if (pos_ready) begin
          w_take = 1'b1;
          if (w_single) w_next_state = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_work  <= numin;
        r_count <= w_popcnt;
      end else if (w_take) begin
        r_work <= r_work & ~(WIDTH'(1) << w_idx);
      end
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_bitpos_scanner.sv
// Directed self-checking bench for bitpos_scanner (both emission orders).
module tb_bitpos_scanner;
  import bitscan_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] numin;
  logic             pos_ready;
  logic             pos_valid;
  logic [IDX_W-1:0] pos;
  logic             last;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  int unsigned n_err;
  int unsigned n_chk;

  bitpos_scanner dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .numin    (numin),
    .pos_ready(pos_ready),
    .pos_valid(pos_valid),
    .pos      (pos),
    .last     (last),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input int unsigned exp_pos,
                      input logic exp_last, input int unsigned exp_cnt);
    check({tag, ".valid"}, 32'(pos_valid), 32'd1);
    check({tag, ".pos"},   32'(pos),       exp_pos);
    check({tag, ".last"},  32'(last),      32'(exp_last));
    check({tag, ".count"}, 32'(count),     exp_cnt);
    check({tag, ".done"},  32'(done),      32'd0);
  endtask

  task automatic launch(input logic [31:0] w);
    start = 1'b1;
    numin = w;
    step();
    start = 1'b0;
    numin = '0;
  endtask

  // Expected index orders for the active build
`ifdef BITSCAN_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
  int unsigned ord2[2] = '{31, 0};
  int unsigned ord4[2] = '{6, 4};
  int unsigned ord5[2] = '{1, 0};
  int unsigned ord6[3] = '{31, 4, 0};
`else
  localparam bit MSB = 1'b0;
  int unsigned ord2[2] = '{0, 31};
  int unsigned ord4[2] = '{4, 6};
  int unsigned ord5[2] = '{0, 1};
  int unsigned ord6[3] = '{0, 4, 31};
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_err     = 0;
    n_chk     = 0;
    reset     = 1'b0;
    start     = 1'b0;
    numin     = '0;
    pos_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    check("rst.valid", 32'(pos_valid), 32'd0);
    check("rst.pos",   32'(pos),       32'd0);
    check("rst.last",  32'(last),      32'd0);
    check("rst.count", 32'(count),     32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.done",  32'(done),      32'd0);
    reset = 1'b1;
    step();

    // 1: zero word
    launch(32'h0000_0000);
    check("zero.valid", 32'(pos_valid), 32'd0);
    check("zero.done",  32'(done),      32'd1);
    check("zero.busy",  32'(busy),      32'd1);
    check("zero.count", 32'(count),     32'd0);
    step();
    check("zero.busy2", 32'(busy), 32'd0);
    check("zero.done2", 32'(done), 32'd0);

    // 2: two bits, ready high
    launch(32'h8000_0001);
    beat("two0", ord2[0], 1'b0, 2);
    step();
    beat("two1", ord2[1], 1'b1, 2);
    step();
    check("two.done",  32'(done),      32'd1);
    check("two.valid", 32'(pos_valid), 32'd0);
    check("two.count", 32'(count),     32'd2);
    step();

    // 3: all ones
    launch(32'hFFFF_FFFF);
    for (int k = 0; k < 32; k++) begin
      beat($sformatf("ones%0d", k), MSB ? 32'(31 - k) : 32'(k), k == 31, 32);
      step();
    end
    check("ones.done",  32'(done),  32'd1);
    check("ones.count", 32'(count), 32'd32);
    step();
    check("ones.idle", 32'(busy), 32'd0);

    // 4: backpressure
    pos_ready = 1'b0;
    launch(32'h0000_0050);
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("bp_hold%0d", k), ord4[0], 1'b0, 2);
      step();
    end
    check("bp.stillvalid", 32'(pos_valid), 32'd1);
    check("bp.stillpos",   32'(pos),       ord4[0]);
    pos_ready = 1'b1;
    step();
    beat("bp1", ord4[1], 1'b1, 2);
    step();
    check("bp.done", 32'(done), 32'd1);
    step();

    // 5a: start during a scan is ignored
    launch(32'h0000_0003);
    beat("ill0", ord5[0], 1'b0, 2);
    start = 1'b1;
    numin = 32'hFFFF_0000;
    step();
    start = 1'b0;
    numin = '0;
    beat("ill1", ord5[1], 1'b1, 2);
    step();
    check("ill.done",  32'(done),  32'd1);
    check("ill.count", 32'(count), 32'd2);
    step();
    check("ill.idle",  32'(busy),  32'd0);
    check("ill.hold",  32'(count), 32'd2);

    // 5b: reset mid-scan
    launch(32'h0000_00F0);
    check("mid.valid0", 32'(pos_valid), 32'd1);
    check("mid.count0", 32'(count),     32'd4);
    reset = 1'b0;
    step();
    check("mid.valid", 32'(pos_valid), 32'd0);
    check("mid.busy",  32'(busy),      32'd0);
    check("mid.count", 32'(count),     32'd0);
    check("mid.done",  32'(done),      32'd0);
    reset = 1'b1;
    step();
    check("mid.done2", 32'(done), 32'd0);
    check("mid.busy2", 32'(busy), 32'd0);

    // 6: three spread bits, build-dependent order
    launch(32'h8000_0011);
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("ord%0d", k), ord6[k], k == 2, 3);
      step();
    end
    check("ord.done", 32'(done), 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bitpos_scanner.md
Name: bitpos_scanner

Overview:
- Counterpart to the team's 32-bit popcount adder. Popcount collapses a word to a count; this block expands a word into the index of every set bit.
- Loads a 32-bit word, snapshots its set-bit count, then emits each set-bit index one per beat over a valid/ready stream.
- Sits beside the P4 datapath as a multicycle helper for bit-iteration instructions and for test harnesses.

Parameters:
- WIDTH, 32, word width (fixed at 32; exposed only for the package constant)
- IDX_W, 5, index width, clog2(WIDTH)
- CNT_W, 6, count width, clog2(WIDTH)+1

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  synchronous, active-low reset
- start  input  1  load request, honoured only in IDLE
- numin  input  32  word to scan, sampled when start is accepted
- pos_ready  input  1  consumer ready
- pos_valid  output  1  pos holds a valid index
- pos  output  5  index of the current set bit
- last  output  1  current beat is the final set bit
- count  output  6  popcount of the loaded word, held until the next load
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when the scan completes

Behaviour:
- Reset: on a clk edge with reset==0, go to IDLE and clear work to 0.
  - All outputs read 0 after reset: pos_valid, pos, last, count, busy, done.
  - Reset applied mid-scan abandons the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE. Internal registers are work[31:0] and state.
- IDLE:
  - start==1 loads work<=numin and count<=popcount(numin).
  - If numin!=0, next state is SCAN; otherwise next state is DONE.
  - start==0 stays in IDLE.
- Latency: first pos_valid is asserted the cycle after start is accepted (T+1).
- SCAN:
  - pos_valid=1.
  - pos = index of the lowest set bit of work (combinational from the work register).
  - last = (work has exactly one bit set).
- Handshake (SCAN):
  - pos_valid && pos_ready clears that bit in work.
  - If it was the last bit, next state is DONE; otherwise stay in SCAN and present the next index the following cycle.
  - Throughput is one index per cycle while pos_ready==1.
- Backpressure: while pos_valid && !pos_ready, pos and last are held stable and work is unchanged.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE. busy=1 in SCAN and DONE.
- start outside IDLE is ignored; numin is not sampled.
- Zero word: no pos beats. done pulses at T+1 with count=0.
- All-ones word: 32 beats, count=32 (needs all 6 bits, no overflow), done at T+33 with ready held high.
- pos_valid is 0 in IDLE and DONE; pos reads 0 when pos_valid==0.
- count is stable for the whole scan and after it, until the next accepted start.

Optional Feature:
- Macro: BITSCAN_MSB_FIRST_EN.
- Defined: pos is the index of the highest set bit of work, so emission order is descending.
- Undefined: order is ascending, lowest bit first.
- All other timing, handshake, count and last behaviour is identical in both builds.

Decomposition:
- Package bitscan_pkg holds:
  - constants WIDTH=32, IDX_W=5, CNT_W=6
  - enum state_t {IDLE, SCAN, DONE}
- One sub-module, bit_prienc32: a combinational 32-to-5 priority encoder with a found flag.
  - Direction is selected by a parameter driven from BITSCAN_MSB_FIRST_EN.
- The popcount for count is computed inline in the top module.

Test Plan:
1. Zero word: numin=0x00000000, start pulse at T -> no pos_valid; done=1 at T+1; count=0; busy=0 at T+2.
2. Two bits, ready high: numin=0x80000001, pos_ready=1 ->
   - T+1: pos=0, last=0
   - T+2: pos=31, last=1
   - T+3: done=1
   - count=2 throughout
3. All ones, ready high: numin=0xFFFFFFFF, pos_ready=1 -> pos=0..31 on consecutive cycles; last only on pos=31; count=32; done at T+33.
4. Backpressure: numin=0x00000050, pos_ready=0 for cycles T+1..T+3 ->
   - pos=4, last=0 held stable for 3 cycles
   - after pos_ready=1: pos=4 then pos=6 with last=1, then done
5. Illegal start and reset:
   - start with numin=0xFFFF0000 during a SCAN of 0x00000003 is ignored, giving indices 0,1 only.
   - Later, reset=0 mid-scan -> next cycle pos_valid=0, busy=0, count=0, and no done pulse.
6. With BITSCAN_MSB_FIRST_EN defined: numin=0x80000011 -> pos=31, 4, 0; last on pos=0; count=3.
